coin_input_conditioner: RTL and testbench

- Sits between hps_io joystick decoding and the galaga core coin/start inputs.
- Turns short, bursty OSD/joystick coin presses into arcade-legal coin pulses of fixed width with a fixed minimum gap.
- Queues coins that arrive faster than the core can accept them, freezes timing while the CPU is paused, and stretches start presses to a minimum width.

---
 rtl/coin_input_conditioner.sv | 232 +++++++++++++++++++++++
 tb/tb_coin_input_conditioner.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/coin_input_conditioner.sv
// -----------------------------------------------------------------------------
// coin_input_conditioner
//
// Sits between the joystick/OSD decoding and the galaga core coin/start inputs.
// Each coin press (a rising edge) is counted into a small per-channel queue.
// A per-channel FSM turns queued coins into fixed-width coin pulses, each
// followed by a fixed minimum low gap. Start presses are stretched to a minimum
// width. While pause is high every timer holds and no new coin is dequeued.
// Edges are still captured while paused.
//
// Ports:
//   clk_sys      in   system clock (18 MHz core clock)
//   reset        in   asynchronous, active-high reset
//   pause        in   CPU pause; freezes all timers and blocks dequeue
//   coin_in      in   [1:0] raw coin buttons, [0]=coin1 [1]=coin2
//   start_in     in   [1:0] raw start buttons, [0]=start1 [1]=start2
//   coin_out     out  [1:0] registered, conditioned coin pulses
//   start_out    out  [1:0] registered, stretched start signals
//   queue_level  out  [2*QUEUE_W-1:0] pending coins per channel, {ch1, ch0}
//   coin_total   out  [15:0] saturating count of issued pulses
//                     (present only when COIN_COUNTER_EN is defined)
//
// Optional feature macro: COIN_COUNTER_EN
// -----------------------------------------------------------------------------
module coin_input_conditioner #(
  parameter int PULSE_CYCLES = 1800000,
  parameter int GAP_CYCLES   = 1800000,
  parameter int START_MIN    = 360000,
  parameter int CNT_W        = 21,
  parameter int QUEUE_W      = 4
) (
  input  logic                   clk_sys,
  input  logic                   reset,
  input  logic                   pause,
  input  logic [1:0]             coin_in,
  input  logic [1:0]             start_in,
  output logic [1:0]             coin_out,
  output logic [1:0]             start_out,
  output logic [2*QUEUE_W-1:0]   queue_level
`ifdef COIN_COUNTER_EN
  ,
  output logic [15:0]            coin_total
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_GAP   = 2'd2
  } coin_state_t;

  // Timers count down to zero, so each phase loads its length minus one.
  localparam logic [CNT_W-1:0]   PULSE_LOAD = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   GAP_LOAD   = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0]   START_LOAD = CNT_W'(START_MIN - 1);
  localparam logic [CNT_W-1:0]   CNT_ZERO   = CNT_W'(0);
  localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);
  localparam logic [QUEUE_W-1:0] Q_ZERO     = QUEUE_W'(0);
  localparam logic [QUEUE_W-1:0] Q_ONE      = QUEUE_W'(1);
  localparam logic [QUEUE_W-1:0] Q_FULL     = {QUEUE_W{1'b1}};

  logic [1:0] coin_in_q_r;
  logic [1:0] start_in_q_r;
  logic [1:0] coin_edge_s;
  logic [1:0] start_edge_s;
  logic [1:0] dequeue_s;

  // Previous-cycle copies of the raw inputs for rising-edge detection.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      coin_in_q_r  <= 2'b00;
      start_in_q_r <= 2'b00;
    end else begin
      coin_in_q_r  <= coin_in;
      start_in_q_r <= start_in;
    end
  end

  // One event per press: a held level never produces a second edge.
  assign coin_edge_s  = coin_in & ~coin_in_q_r;
  assign start_edge_s = start_in & ~start_in_q_r;

  for (genvar ch = 0; ch < 2; ch++) begin : g_chan
    coin_state_t        state_r;
    coin_state_t        state_s;
    logic [CNT_W-1:0]   timer_r;
    logic [CNT_W-1:0]   timer_s;
    logic [QUEUE_W-1:0] queue_r;
    logic [QUEUE_W-1:0] queue_s;
    logic               deq_s;
    logic               coin_out_r;
    logic [CNT_W-1:0]   stretch_r;
    logic [CNT_W-1:0]   stretch_s;
    logic               start_out_r;

    // Coin FSM next state, timer and dequeue strobe.
    always_comb begin
      state_s = state_r;
      timer_s = timer_r;
      deq_s   = 1'b0;
      case (state_r)
        ST_IDLE: begin
          if ((queue_r != Q_ZERO) && !pause) begin
            state_s = ST_PULSE;
            timer_s = PULSE_LOAD;
            deq_s   = 1'b1;
          end else begin
            state_s = ST_IDLE;
            timer_s = timer_r;
          end
        end
        ST_PULSE: begin
          if (pause) begin
            timer_s = timer_r;
          end else if (timer_r == CNT_ZERO) begin
            state_s = ST_GAP;
            timer_s = GAP_LOAD;
          end else begin
            timer_s = timer_r - CNT_ONE;
          end
        end
        ST_GAP: begin
          if (pause) begin
            timer_s = timer_r;
          end else if (timer_r == CNT_ZERO) begin
            state_s = ST_IDLE;
            timer_s = CNT_ZERO;
          end else begin
            timer_s = timer_r - CNT_ONE;
          end
        end
        default: begin
          state_s = ST_IDLE;
          timer_s = CNT_ZERO;
        end
      endcase
    end

    // Queue update: an edge and a dequeue in the same cycle cancel, so a
    // full queue still accepts a coin when one leaves at the same time.
    always_comb begin
      queue_s = queue_r;
      case ({coin_edge_s[ch], deq_s})
        2'b10: begin
          if (queue_r == Q_FULL) begin
            queue_s = queue_r;
          end else begin
            queue_s = queue_r + Q_ONE;
          end
        end
        2'b01:   queue_s = queue_r - Q_ONE;
        default: queue_s = queue_r;
      endcase
    end

    // Start stretch timer: a fresh press reloads, otherwise count down unless paused.
    always_comb begin
      stretch_s = stretch_r;
      if (start_edge_s[ch]) begin
        stretch_s = START_LOAD;
      end else if (!pause && (stretch_r != CNT_ZERO)) begin
        stretch_s = stretch_r - CNT_ONE;
      end else begin
        stretch_s = stretch_r;
      end
    end

    // Channel state registers; coin_out is decoded from the next state so it
    // is high exactly while the FSM sits in PULSE.
    always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
        state_r     <= ST_IDLE;
        timer_r     <= CNT_ZERO;
        queue_r     <= Q_ZERO;
        coin_out_r  <= 1'b0;
        stretch_r   <= CNT_ZERO;
        start_out_r <= 1'b0;
      end else begin
        state_r     <= state_s;
        timer_r     <= timer_s;
        queue_r     <= queue_s;
        coin_out_r  <= (state_s == ST_PULSE);
        stretch_r   <= stretch_s;
        start_out_r <= start_in[ch] | (stretch_r != CNT_ZERO);
      end
    end

    assign dequeue_s[ch]                          = deq_s;
    assign coin_out[ch]                           = coin_out_r;
    assign start_out[ch]                          = start_out_r;
    assign queue_level[ch*QUEUE_W +: QUEUE_W]     = queue_r;
  end

`ifdef COIN_COUNTER_EN
  logic [15:0] total_r;
  logic [15:0] total_s;

  // Saturating pulse counter; both channels can start a pulse in one cycle.
  always_comb begin
    total_s = total_r;
    case (dequeue_s)
      2'b01, 2'b10: begin
        if (total_r != 16'hFFFF) begin
          total_s = total_r + 16'd1;
        end else begin
          total_s = total_r;
        end
      end
      2'b11: begin
        if (total_r < 16'hFFFE) begin
          total_s = total_r + 16'd2;
        end else begin
          total_s = 16'hFFFF;
        end
      end
      default: total_s = total_r;
    endcase
  end

  // Pulse counter register.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      total_r <= 16'd0;
    end else begin
      total_r <= total_s;
    end
  end

  assign coin_total = total_r;
`endif

endmodule

// File: tb/tb_coin_input_conditioner.sv
`timescale 1ns/1ps
module tb_coin_input_conditioner;

  localparam int PULSE_CYCLES = 4;
  localparam int GAP_CYCLES   = 3;
  localparam int START_MIN    = 5;
  localparam int CNT_W        = 4;
  localparam int QUEUE_W      = 2;
  localparam int QMAX         = (1 << QUEUE_W) - 1;

  logic                 clk_sys = 1'b0;
  logic                 reset;
  logic                 pause;
  logic [1:0]           coin_in;
  logic [1:0]           start_in;
  logic [1:0]           coin_out;
  logic [1:0]           start_out;
  logic [2*QUEUE_W-1:0] queue_level;
`ifdef COIN_COUNTER_EN
  logic [15:0]          coin_total;
`endif

  int checks = 0;
  int errors = 0;

  coin_input_conditioner #(
    .PULSE_CYCLES(PULSE_CYCLES),
    .GAP_CYCLES  (GAP_CYCLES),
    .START_MIN   (START_MIN),
    .CNT_W       (CNT_W),
    .QUEUE_W     (QUEUE_W)
  ) dut (
    .clk_sys     (clk_sys),
    .reset       (reset),
    .pause       (pause),
    .coin_in     (coin_in),
    .start_in    (start_in),
    .coin_out    (coin_out),
    .start_out   (start_out),
    .queue_level (queue_level)
`ifdef COIN_COUNTER_EN
    ,
    .coin_total  (coin_total)
`endif
  );

  always #5 clk_sys = ~clk_sys;

  // Reference model: pending coins, remaining unpaused cycles of the current
  // pulse+gap window, remaining unpaused high cycles, remaining minimum start width.
  int         m_q[2];
  int         m_busy[2];
  int         m_hi[2];
  int         m_smin[2];
  logic [1:0] m_cprev;
  logic [1:0] m_sprev;
  logic [1:0] m_start_out;
  int         m_total;
  int         cyc;

  // Observation statistics taken from the DUT outputs.
  int         hi_cnt[2];
  int         rise_cnt[2];
  int         shi_cnt[2];
  logic [1:0] obs_prev;
  int         rise_at[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int ch = 0; ch < 2; ch++) begin
      m_q[ch] = 0; m_busy[ch] = 0; m_hi[ch] = 0; m_smin[ch] = 0;
    end
    m_cprev = 2'b00; m_sprev = 2'b00; m_start_out = 2'b00; m_total = 0;
    obs_prev = 2'b00;
  endtask

  task automatic clear_obs();
    for (int ch = 0; ch < 2; ch++) begin
      hi_cnt[ch] = 0; rise_cnt[ch] = 0; shi_cnt[ch] = 0;
    end
    rise_at.delete();
  endtask

  task automatic model_tick();
    for (int ch = 0; ch < 2; ch++) begin
      logic edge_c, deq, edge_s;
      edge_c = coin_in[ch] & ~m_cprev[ch];
      deq    = (m_busy[ch] == 0) && (m_q[ch] > 0) && !pause;
      if (m_busy[ch] > 0 && !pause) begin
        m_busy[ch]--;
        if (m_hi[ch] > 0) m_hi[ch]--;
      end
      if (deq) begin
        m_busy[ch] = PULSE_CYCLES + GAP_CYCLES;
        m_hi[ch]   = PULSE_CYCLES;
        if (m_total < 65535) m_total++;
      end
      m_q[ch] = m_q[ch] + (edge_c ? 1 : 0) - (deq ? 1 : 0);
      if (m_q[ch] > QMAX) m_q[ch] = QMAX;
      edge_s = start_in[ch] & ~m_sprev[ch];
      m_start_out[ch] = start_in[ch] | (m_smin[ch] > 0);
      if (edge_s) m_smin[ch] = START_MIN - 1;
      else if (!pause && m_smin[ch] > 0) m_smin[ch]--;
    end
    m_cprev = coin_in;
    m_sprev = start_in;
  endtask

  function automatic logic [2*QUEUE_W-1:0] exp_queue();
    logic [QUEUE_W-1:0] q0, q1;
    q0 = QUEUE_W'(m_q[0]);
    q1 = QUEUE_W'(m_q[1]);
    return {q1, q0};
  endfunction

  // One clock cycle: apply inputs, advance model, compare after the edge.
  task automatic step(input logic [1:0] c, input logic [1:0] s, input logic p);
    logic [1:0] exp_coin;
    coin_in = c; start_in = s; pause = p;
    @(posedge clk_sys);
    cyc++;
    model_tick();
    #1;
    exp_coin = {m_hi[1] > 0, m_hi[0] > 0};
    check("coin_out", 32'(coin_out), 32'(exp_coin));
    check("start_out", 32'(start_out), 32'(m_start_out));
    check("queue_level", 32'(queue_level), 32'(exp_queue()));
`ifdef COIN_COUNTER_EN
    check("coin_total", 32'(coin_total), 32'(m_total));
`endif
    for (int ch = 0; ch < 2; ch++) begin
      if (coin_out[ch] === 1'b1) hi_cnt[ch]++;
      if (start_out[ch] === 1'b1) shi_cnt[ch]++;
      if (coin_out[ch] === 1'b1 && obs_prev[ch] === 1'b0) begin
        rise_cnt[ch]++;
        if (ch == 0) rise_at.push_back(cyc + 1);
      end
    end
    obs_prev = coin_out;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(2'b00, 2'b00, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_coin"}, 32'(coin_out), 32'd0);
    check({tag, "_start"}, 32'(start_out), 32'd0);
    check({tag, "_queue"}, 32'(queue_level), 32'd0);
`ifdef COIN_COUNTER_EN
    check({tag, "_total"}, 32'(coin_total), 32'd0);
`endif
  endtask

  initial begin
    int t0;
    reset = 1'b1; pause = 1'b0; coin_in = 2'b00; start_in = 2'b00;
    cyc = 0;
    model_reset();
    clear_obs();
    repeat (3) @(posedge clk_sys);
    #1;
    check_reset_outputs("reset_state");
    reset = 1'b0;
    idle(3);

    // Single coin: queue at +1, pulse t0+2..t0+5.
    clear_obs();
    t0 = cyc + 1;
    step(2'b01, 2'b00, 1'b0);
    check("single_q_plus1", 32'(queue_level[QUEUE_W-1:0]), 32'd1);
    idle(12);
    check("single_hi_cycles", 32'(hi_cnt[0]), 32'd4);
    check("single_pulses", 32'(rise_cnt[0]), 32'd1);
    if (rise_at.size() > 0) check("single_rise_time", 32'(rise_at[0]), 32'(t0 + 2));
    else check("single_rise_seen", 32'd0, 32'd1);

    // Burst: 5 edges in 10 cycles, one dropped at saturation.
    clear_obs();
    for (int i = 0; i < 10; i++) step((i % 2 == 0) ? 2'b01 : 2'b00, 2'b00, 1'b0);
    idle(40);
    check("burst_pulses", 32'(rise_cnt[0]), 32'd4);
    check("burst_hi_cycles", 32'(hi_cnt[0]), 32'd16);
    for (int i = 0; i + 1 < rise_at.size(); i++)
      check("burst_period", 32'(rise_at[i+1] - rise_at[i]), 32'd8);

    // Pause mid-pulse after two pulse cycles.
    clear_obs();
    step(2'b01, 2'b00, 1'b0);
    idle(3);
    for (int i = 0; i < 10; i++) step(2'b00, 2'b00, 1'b1);
    idle(15);
    check("pause_pulse_len", 32'(hi_cnt[0]), 32'd14);
    check("pause_pulses", 32'(rise_cnt[0]), 32'd1);

    // Pause in IDLE: edge queued, no dequeue until released.
    clear_obs();
    step(2'b01, 2'b00, 1'b1);
    for (int i = 0; i < 4; i++) step(2'b00, 2'b00, 1'b1);
    check("pause_idle_queue", 32'(queue_level[QUEUE_W-1:0]), 32'd1);
    check("pause_idle_nopulse", 32'(rise_cnt[0]), 32'd0);
    idle(15);
    check("pause_idle_after", 32'(rise_cnt[0]), 32'd1);

    // Edge in the same cycle as a dequeue with queue=1.
    clear_obs();
    step(2'b01, 2'b00, 1'b0);
    idle(2);
    step(2'b01, 2'b00, 1'b0);
    idle(5);
    step(2'b01, 2'b00, 1'b0);
    check("edge_deq_queue", 32'(queue_level[QUEUE_W-1:0]), 32'd1);
    idle(30);
    check("edge_deq_pulses", 32'(rise_cnt[0]), 32'd3);

    // Both channels at once.
    clear_obs();
    step(2'b11, 2'b00, 1'b0);
    idle(12);
    check("dual_pulses0", 32'(rise_cnt[0]), 32'd1);
    check("dual_pulses1", 32'(rise_cnt[1]), 32'd1);
    check("dual_hi1", 32'(hi_cnt[1]), 32'd4);

    // Start stretch: 1-cycle press and 20-cycle press.
    clear_obs();
    step(2'b00, 2'b10, 1'b0);
    idle(10);
    check("start_short", 32'(shi_cnt[1]), 32'd5);
    clear_obs();
    for (int i = 0; i < 20; i++) step(2'b00, 2'b10, 1'b0);
    idle(10);
    check("start_long", 32'(shi_cnt[1]), 32'd20);

    // Async reset mid-pulse with queue=2 and a start being stretched.
    clear_obs();
    step(2'b01, 2'b00, 1'b0);
    step(2'b00, 2'b00, 1'b0);
    step(2'b01, 2'b00, 1'b0);
    step(2'b00, 2'b10, 1'b0);
    step(2'b01, 2'b00, 1'b0);
    coin_in = 2'b00; start_in = 2'b00; pause = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check_reset_outputs("async_reset");
    model_reset();
    @(posedge clk_sys);
    #1;
    reset = 1'b0;
    clear_obs();
    idle(20);
    check("post_reset_nopulse", 32'(rise_cnt[0]), 32'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      logic [1:0] c, s;
      logic p;
      c[0] = ($urandom_range(0, 5) == 0);
      c[1] = ($urandom_range(0, 5) == 0);
      s[0] = ($urandom_range(0, 3) == 0);
      s[1] = ($urandom_range(0, 3) == 0);
      p    = ($urandom_range(0, 7) == 0);
      step(c, s, p);
    end
    idle(20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
